key_action_scheduler: RTL



---
 rtl/key_pkg.sv | 30 +++
 rtl/key_debouncer.sv | 62 ++++++
 rtl/key_action_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key action scheduler.
// Mode encoding, key slot indices and player ids used across the block.
package key_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } mode_t;

    localparam int K_P1C    = 0;
    localparam int K_P2C    = 1;
    localparam int K_LEFT   = 2;
    localparam int K_RIGHT  = 3;
    localparam int K_ENTER  = 4;
    localparam int K_SPACE  = 5;
    localparam int K_UP1    = 6;
    localparam int K_UP2    = 7;
    localparam int NUM_KEYS = 8;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    // One-hot pending mask for a player id.
    function automatic logic [1:0] player_mask(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Single-key 2-flop synchroniser, frame-tick debounce counter and press pulse.
// press_o is high for the one Clk cycle following a 0->1 flip of level_o.
module key_debouncer #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int CNT_W           = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    logic             sync1_q, sync2_q;
    logic             state_q, state_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: count consecutive frame ticks on which the synced flag disagrees.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (frame_tick_i) begin
            if (sync2_q != state_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                    state_d = ~state_q;
                    cnt_d   = '0;
                    press_d = ~state_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Synchroniser, debounce state and pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign level_o = state_q;
    assign press_o = press_q;

endmodule

// File: rtl/key_action_scheduler.sv
// Debounces game keys, runs the game-mode FSM and arbitrates catch launches.
// Optional left/right auto-repeat is built when KEY_AUTO_REPEAT_EN is defined.
module key_action_scheduler
    import key_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_FRAMES   = 6,
    parameter int CNT_W           = 5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       p1_catch,
    input  logic       p2_catch,
    input  logic       left,
    input  logic       right,
    input  logic       enter,
    input  logic       space,
    input  logic       up1,
    input  logic       up2,
    input  logic       time_up,
    input  logic [1:0] hook_busy,
    input  logic       launch_ready,
    output logic [1:0] mode,
    output logic       left_pulse,
    output logic       right_pulse,
    output logic       up1_pulse,
    output logic       up2_pulse,
    output logic       launch_valid,
    output logic       launch_id,
    output logic [1:0] pending
);

    logic [NUM_KEYS-1:0] raw_s, level_s, press_s;
    logic [1:0]          catch_press_s, rep_fire_s;
    logic                in_play_s, transfer_s;

    mode_t      mode_q, mode_d;
    logic [1:0] pending_q, pending_d;
    logic       valid_q, valid_d, id_q, id_d, rr_q, rr_d;
    logic       left_q, left_d, right_q, right_d, up1_q, up1_d, up2_q, up2_d;

    assign raw_s = {up2, up1, space, enter, right, left, p2_catch, p1_catch};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk_i       (Clk),
            .rst_ni      (Reset_n),
            .frame_tick_i(frame_tick),
            .raw_i       (raw_s[k]),
            .level_o     (level_s[k]),
            .press_o     (press_s[k])
        );
    end

    assign in_play_s     = (mode_q == PLAY);
    assign catch_press_s = {press_s[K_P2C], press_s[K_P1C]};

`ifdef KEY_AUTO_REPEAT_EN
    logic [1:0][CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]            rep_armed_q, rep_armed_d, dir_level_s;

    assign dir_level_s = {level_s[K_RIGHT], level_s[K_LEFT]};

    // Auto-repeat timers for left (0) and right (1); first period is the longer delay.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire_s  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (in_play_s && dir_level_s[i]) begin
                if (frame_tick) begin
                    if ((!rep_armed_q[i] && rep_cnt_q[i] == CNT_W'(REPEAT_DELAY - 1)) ||
                        ( rep_armed_q[i] && rep_cnt_q[i] == CNT_W'(REPEAT_FRAMES - 1))) begin
                        rep_fire_s[i]  = 1'b1;
                        rep_cnt_d[i]   = '0;
                        rep_armed_d[i] = 1'b1;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i];
                end
            end else begin
                rep_cnt_d[i]   = '0;
                rep_armed_d[i] = 1'b0;
            end
        end
    end

    // Auto-repeat state registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 2'b00;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_FRAMES;
    logic unused_level_s;
    assign unused_level_s = ^level_s;
    assign rep_fire_s     = 2'b00;
`endif

    // Game-mode FSM; time_up outranks a simultaneous space press.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            TITLE: begin
                if (press_s[K_ENTER]) mode_d = PLAY;
                else                  mode_d = TITLE;
            end
            PLAY: begin
                if (time_up)               mode_d = OVER;
                else if (press_s[K_SPACE]) mode_d = PAUSE;
                else                       mode_d = PLAY;
            end
            PAUSE: begin
                if (press_s[K_SPACE]) mode_d = PLAY;
                else                  mode_d = PAUSE;
            end
            OVER: begin
                if (press_s[K_ENTER]) mode_d = TITLE;
                else                  mode_d = OVER;
            end
            default: mode_d = TITLE;
        endcase
    end

    // Catch arbitration: a presented request is held until it transfers, even outside PLAY.
    always_comb begin
        transfer_s = valid_q & launch_ready;
        pending_d  = pending_q;
        valid_d    = valid_q;
        id_d       = id_q;
        rr_d       = rr_q;
        if (transfer_s) begin
            pending_d = pending_q & ~player_mask(id_q);
            valid_d   = 1'b0;
            rr_d      = ~id_q;
        end else if (!valid_q && in_play_s && (pending_q != 2'b00)) begin
            valid_d = 1'b1;
            id_d    = (&pending_q) ? rr_q : pending_q[1];
        end else begin
            valid_d = valid_q;
        end
        if (in_play_s) begin
            for (int i = 0; i < 2; i++) begin
                if (catch_press_s[i] && !hook_busy[i] && !pending_q[i]) begin
                    pending_d[i] = 1'b1;
                end else begin
                    pending_d[i] = pending_d[i];
                end
            end
        end else begin
            pending_d = pending_d & (valid_q ? player_mask(id_q) : 2'b00);
        end
    end

    // Direction and up pulses exist only in PLAY.
    always_comb begin
        left_d  = in_play_s & (press_s[K_LEFT]  | rep_fire_s[0]);
        right_d = in_play_s & (press_s[K_RIGHT] | rep_fire_s[1]);
        up1_d   = in_play_s & press_s[K_UP1];
        up2_d   = in_play_s & press_s[K_UP2];
    end

    // Output and control state registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_q    <= TITLE;
            pending_q <= 2'b00;
            valid_q   <= 1'b0;
            id_q      <= PLAYER1;
            rr_q      <= PLAYER1;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            up1_q     <= 1'b0;
            up2_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
            left_q    <= left_d;
            right_q   <= right_d;
            up1_q     <= up1_d;
            up2_q     <= up2_d;
        end
    end

    assign mode         = mode_q;
    assign pending      = pending_q;
    assign launch_valid = valid_q;
    assign launch_id    = id_q;
    assign left_pulse   = left_q;
    assign right_pulse  = right_q;
    assign up1_pulse    = up1_q;
    assign up2_pulse    = up2_q;

endmodule
